// File: rtl/lcm_from_gcd_if.sv
// Handshake and data bundle between the GCD result capture, the LCM stage and its consumer.
interface lcm_from_gcd_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     m_in;
  logic [WIDTH-1:0]     n_in;
  logic [WIDTH-1:0]     g_in;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [2*WIDTH-1:0]   lcm;

  modport master (
    output start, m_in, n_in, g_in,
    input  busy, done, err, lcm
  );

  modport slave (
    input  start, m_in, n_in, g_in,
    output busy, done, err, lcm
  );
endinterface

// File: rtl/lcm_from_gcd.sv
// LCM = (M / G) * N using a WIDTH-step restoring divider followed by a WIDTH-step
// shift-add multiplier; one operation in flight, start/busy/done handshake.
module lcm_from_gcd #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  lcm_from_gcd_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]           state;
  logic [CW-1:0]        step;
  logic [WIDTH-1:0]     g_r;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvd;     // dividend, becomes quotient, then scanned LSB-first
  logic [2*WIDTH-1:0]   mcand;   // N shifted left by the current multiply step
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   lcm_r;
  logic                 err_r;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, g_r};
    q_bit    = ~trial[WIDTH];
    // a failed trial implies shifted < G, so the low WIDTH bits hold it exactly
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    acc_next = dvd[0] ? acc + mcand : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= '0;
      g_r   <= '0;
      rem   <= '0;
      dvd   <= '0;
      mcand <= '0;
      acc   <= '0;
      lcm_r <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            g_r   <= bus.g_in;
            mcand <= {{WIDTH{1'b0}}, bus.n_in};
            dvd   <= bus.m_in;
            rem   <= '0;
            step  <= '0;
            if (bus.g_in == '0) begin
              err_r <= 1'b1;
              lcm_r <= '0;
              state <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          if (step == LAST) begin
            step <= '0;
            acc  <= '0;
            if (rem_next != '0) begin
              err_r <= 1'b1;
              lcm_r <= '0;
              state <= S_DONE;
            end else begin
              state <= S_MUL;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        S_MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          dvd   <= dvd >> 1;
          if (step == LAST) begin
            step  <= '0;
            lcm_r <= acc_next;
            err_r <= 1'b0;
            state <= S_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.err  = err_r;
  assign bus.lcm  = lcm_r;
endmodule

// File: tb/tb_lcm_from_gcd.sv
// Table-driven bench for lcm_from_gcd with an expected-result queue and corner sequences.
module tb_lcm_from_gcd;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  lcm_from_gcd_if #(.WIDTH(W)) bus ();

  lcm_from_gcd #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   n;
    logic [W-1:0]   g;
    logic [2*W-1:0] lcm;
    logic           err;
    int             lat;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] lcm;
    logic           err;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive one operation; optional second start pulse after edge overlap_at.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] n, input logic [W-1:0] g,
                        input logic [2*W-1:0] e_lcm, input logic e_err, input int e_lat,
                        input int overlap_at);
    exp_t e;
    exp_t got_e;
    int   k;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.m_in  = m;
    bus.n_in  = n;
    bus.g_in  = g;
    e.lcm = e_lcm; e.err = e_err; e.lat = e_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    k = 1;
    bus.start = 1'b0;
    bus.m_in  = W'($urandom);
    bus.n_in  = W'($urandom);
    bus.g_in  = W'($urandom);
    chk("busy_rise", 32'(bus.busy), 32'd1);
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
      bus.start = 1'b0;
      if (k == overlap_at) begin
        bus.start = 1'b1;
        bus.m_in  = 8'd100;
        bus.n_in  = 8'd3;
        bus.g_in  = 8'd1;
      end
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      chk("done_timeout", 32'(k), 32'(e_lat));
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("sb_empty_on_done", 32'd0, 32'd1);
    end else begin
      got_e = sb.pop_front();
      chk("latency", 32'(k), 32'(got_e.lat));
      chk("lcm", 32'(bus.lcm), 32'(got_e.lcm));
      chk("err", 32'(bus.err), 32'(got_e.err));
      chk("busy_in_done", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      chk("done_pulse_len", 32'(bus.done), 32'd0);
      chk("busy_fall", 32'(bus.busy), 32'd0);
      chk("lcm_hold", 32'(bus.lcm), 32'(got_e.lcm));
      chk("err_hold", 32'(bus.err), 32'(got_e.err));
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
  endtask

  vec_t vecs[10];
  int   cnt;

  initial begin
    vecs[0] = '{m: 8'd12,  n: 8'd18,  g: 8'd6,   lcm: 16'd36,    err: 1'b0, lat: 17};
    vecs[1] = '{m: 8'd255, n: 8'd254, g: 8'd1,   lcm: 16'hFD02,  err: 1'b0, lat: 17};
    vecs[2] = '{m: 8'd255, n: 8'd255, g: 8'd255, lcm: 16'd255,   err: 1'b0, lat: 17};
    vecs[3] = '{m: 8'd0,   n: 8'd7,   g: 8'd7,   lcm: 16'd0,     err: 1'b0, lat: 17};
    vecs[4] = '{m: 8'd5,   n: 8'd5,   g: 8'd0,   lcm: 16'd0,     err: 1'b1, lat: 1};
    vecs[5] = '{m: 8'd12,  n: 8'd18,  g: 8'd5,   lcm: 16'd0,     err: 1'b1, lat: 9};
    vecs[6] = '{m: 8'd12,  n: 8'd18,  g: 8'd6,   lcm: 16'd36,    err: 1'b0, lat: 17};
    vecs[7] = '{m: 8'd7,   n: 8'd0,   g: 8'd7,   lcm: 16'd0,     err: 1'b0, lat: 17};
    vecs[8] = '{m: 8'd200, n: 8'd150, g: 8'd50,  lcm: 16'd600,   err: 1'b0, lat: 17};
    vecs[9] = '{m: 8'd1,   n: 8'd1,   g: 8'd1,   lcm: 16'd1,     err: 1'b0, lat: 17};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.m_in  = '0;
    bus.n_in  = '0;
    bus.g_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err",  32'(bus.err),  32'd0);
    chk("rst_lcm",  32'(bus.lcm),  32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].m, vecs[i].n, vecs[i].g, vecs[i].lcm, vecs[i].err, vecs[i].lat, 0);

    // Random divisible operands against a behavioural model.
    for (int i = 0; i < 8; i++) begin
      int unsigned g, k, n;
      g = $urandom_range(1, 255);
      k = $urandom_range(0, 255 / g);
      n = $urandom_range(0, 255);
      run_op(W'(g * k), W'(n), W'(g), 16'(k * n), 1'b0, 17, 0);
    end

    // Second start while busy must be dropped.
    run_op(8'd12, 8'd18, 8'd6, 16'd36, 1'b0, 17, 5);
    count_dones(25, cnt);
    chk("overlap_no_extra_done", 32'(cnt), 32'd0);
    chk("overlap_lcm_kept", 32'(bus.lcm), 32'd36);

    // Reset mid-operation abandons it.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.m_in  = 8'd12;
    bus.n_in  = 8'd18;
    bus.g_in  = 8'd6;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_lcm",  32'(bus.lcm),  32'd0);
    chk("midrst_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;
    count_dones(25, cnt);
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run_op(8'd12, 8'd18, 8'd6, 16'd36, 1'b0, 17, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
